// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD vector ALU: op encodings and lane slice/saturation helpers.
package simd_pkg;

   typedef enum logic [2:0] {
      VOP_VADD   = 3'b000,
      VOP_VSUB   = 3'b001,
      VOP_VAND   = 3'b010,
      VOP_VMUL   = 3'b011,
      VOP_VMAC   = 3'b100,
      VOP_VMOV   = 3'b101,
      VOP_ACCCLR = 3'b110,
      VOP_VDOT   = 3'b111
   } vop_e;

   typedef enum logic [1:0] {
      SAT_NONE = 2'b00,
      SAT_MAX  = 2'b01,
      SAT_MIN  = 2'b10
   } sat_sel_e;

   // Bit offset of a lane inside a packed vector.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
      return lane * lane_w;
   endfunction

   // Signed add overflow from operand and result sign bits (pass ~b sign for subtraction).
   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   // On overflow the first operand's sign tells which rail the true result passed.
   function automatic sat_sel_e sat_select(input logic sat, input logic ovf, input logic neg);
      if (!(sat && ovf)) return SAT_NONE;
      return neg ? SAT_MIN : SAT_MAX;
   endfunction

endpackage

// File: rtl/simd_lane.sv
// One combinational SIMD lane: add/sub with optional saturation, and, mul, mac and move.
module simd_lane
   import simd_pkg::*;
#(
   parameter int unsigned LANE_W = 16
) (
   input  vop_e              op,
   input  logic              sat,
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   input  logic [LANE_W-1:0] acc,
   output logic [LANE_W-1:0] res_c,
   output logic [LANE_W-1:0] prod_c,
   output logic              ovf_c
);

   localparam int unsigned MSB = LANE_W - 1;
   localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
   localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

   logic [LANE_W-1:0] sum;
   logic [LANE_W-1:0] diff;
   logic [LANE_W-1:0] mac;
   sat_sel_e          ssel;

   always_comb begin
      // Low half of a signed product equals the low half of the unsigned product.
      prod_c = a * b;
      sum    = a + b;
      diff   = a - b;
      mac    = acc + prod_c;
      res_c  = '0;
      ovf_c  = 1'b0;
      ssel   = SAT_NONE;
      unique case (op)
         VOP_VADD: begin
            res_c = sum;
            ovf_c = add_ovf(a[MSB], b[MSB], sum[MSB]);
            ssel  = sat_select(sat, ovf_c, a[MSB]);
         end
         VOP_VSUB: begin
            res_c = diff;
            ovf_c = add_ovf(a[MSB], ~b[MSB], diff[MSB]);
            ssel  = sat_select(sat, ovf_c, a[MSB]);
         end
         VOP_VAND: res_c = a & b;
         VOP_VMUL: res_c = prod_c;
         VOP_VMAC: begin
            res_c = mac;
            ovf_c = add_ovf(acc[MSB], prod_c[MSB], mac[MSB]);
         end
         VOP_VMOV: res_c = a;
         default:  res_c = '0;
      endcase
      case (ssel)
         SAT_MAX: res_c = SMAX;
         SAT_MIN: res_c = SMIN;
         default: ;
      endcase
   end

endmodule

// File: rtl/simd_valu_pipe.sv
// Two-stage pipelined SIMD vector ALU with valid/ready on both sides and a per-lane accumulator.
module simd_valu_pipe
   import simd_pkg::*;
#(
   parameter int unsigned LANE_W = 16,
   parameter int unsigned LANES  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               op,
   input  logic                     sat,
   input  logic [LANE_W*LANES-1:0]  a,
   input  logic [LANE_W*LANES-1:0]  b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANE_W*LANES-1:0]  result,
   output logic [LANES-1:0]         ovf_mask,
   output logic                     zero
);

   localparam int unsigned VW = LANE_W * LANES;

   logic              s1_valid;
   vop_e              s1_op;
   logic              s1_sat;
   logic [VW-1:0]     s1_a;
   logic [VW-1:0]     s1_b;
   logic [VW-1:0]     acc;
   logic [VW-1:0]     lane_res;
   logic [VW-1:0]     lane_prod;
   logic [LANES-1:0]  lane_ovf;
   logic [LANE_W-1:0] dot_sum;
   logic [VW-1:0]     nxt_result;
   logic              adv_c;

   assign adv_c    = !out_valid || out_ready;
   assign in_ready = !s1_valid || adv_c;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      simd_lane #(.LANE_W(LANE_W)) u_lane (
         .op     (s1_op),
         .sat    (s1_sat),
         .a      (s1_a[lane_lsb(i, LANE_W) +: LANE_W]),
         .b      (s1_b[lane_lsb(i, LANE_W) +: LANE_W]),
         .acc    (acc[lane_lsb(i, LANE_W) +: LANE_W]),
         .res_c  (lane_res[lane_lsb(i, LANE_W) +: LANE_W]),
         .prod_c (lane_prod[lane_lsb(i, LANE_W) +: LANE_W]),
         .ovf_c  (lane_ovf[i])
      );
   end

   // Dot product reduction; lanes output zero for VDOT so only lane 0 is overridden.
   always_comb begin
      dot_sum = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         dot_sum = dot_sum + lane_prod[lane_lsb(i, LANE_W) +: LANE_W];
      end
      nxt_result = lane_res;
      if (s1_op == VOP_VDOT) nxt_result[LANE_W-1:0] = dot_sum;
   end

   // Stage 1: operand capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= VOP_VADD;
         s1_sat   <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op  <= vop_e'(op);
            s1_sat <= sat;
            s1_a   <= a;
            s1_b   <= b;
         end
      end
   end

   // Stage 2: result/flags; the accumulator moves only when its op leaves stage 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         ovf_mask  <= '0;
         zero      <= 1'b1;
         acc       <= '0;
      end else if (adv_c) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result   <= nxt_result;
            ovf_mask <= lane_ovf;
            zero     <= ~|nxt_result;
            if (s1_op == VOP_VMAC)        acc <= lane_res;
            else if (s1_op == VOP_ACCCLR) acc <= '0;
         end
      end
   end

endmodule

// File: tb/tb_simd_valu_pipe.sv
// Directed self-checking bench for simd_valu_pipe with hand-computed expected vectors.
module tb_simd_valu_pipe;
   import simd_pkg::*;

   localparam int unsigned LANE_W = 16;
   localparam int unsigned LANES  = 16;
   localparam int unsigned VW     = LANE_W * LANES;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       op = 3'b000;
   logic             sat = 1'b0;
   logic [VW-1:0]    a = '0;
   logic [VW-1:0]    b = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [VW-1:0]    result;
   logic [LANES-1:0] ovf_mask;
   logic             zero;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   simd_valu_pipe #(.LANE_W(LANE_W), .LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .sat       (sat),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf_mask  (ovf_mask),
      .zero      (zero)
   );

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] fill(input logic [LANE_W-1:0] v);
      return {LANES{v}};
   endfunction

   // Single op through an empty pipe: checks latency, result and flags.
   task automatic run_op(input string tag, input logic [2:0] o, input logic s,
                         input logic [VW-1:0] va, input logic [VW-1:0] vb,
                         input logic [VW-1:0] exp_res, input logic [LANES-1:0] exp_ovf);
      @(negedge clk);
      in_valid = 1'b1; op = o; sat = s; a = va; b = vb;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, " early"}, VW'(out_valid), VW'(0));
      @(negedge clk);
      chk({tag, " valid"}, VW'(out_valid), VW'(1));
      chk({tag, " result"}, result, exp_res);
      chk({tag, " ovf"}, VW'(ovf_mask), VW'(exp_ovf));
      chk({tag, " zero"}, VW'(zero), VW'(exp_res == '0));
   endtask

   initial begin
      logic [VW-1:0] va;
      logic [VW-1:0] vb;
      logic [VW-1:0] ve;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst out_valid", VW'(out_valid), VW'(0));
      chk("rst result", result, '0);
      chk("rst zero", VW'(zero), VW'(1));
      chk("rst ovf", VW'(ovf_mask), '0);
      chk("rst in_ready", VW'(in_ready), VW'(1));
      rst_n = 1'b1;

      run_op("vadd", VOP_VADD, 1'b0, fill(16'h0003), fill(16'h0004), fill(16'h0007), '0);

      // Saturation boundaries on lanes 0 and 1
      va = '0; vb = '0; ve = '0;
      va[15:0] = 16'h7FFF; va[31:16] = 16'h8000;
      vb[15:0] = 16'h0001; vb[31:16] = 16'hFFFF;
      ve[15:0] = 16'h7FFF; ve[31:16] = 16'h8000;
      run_op("vadd sat", VOP_VADD, 1'b1, va, vb, ve, 16'h0003);
      ve[15:0] = 16'h8000; ve[31:16] = 16'h7FFF;
      run_op("vadd wrap", VOP_VADD, 1'b0, va, vb, ve, 16'h0003);
      run_op("vsub", VOP_VSUB, 1'b0, fill(16'h0005), fill(16'h0007), fill(16'hFFFE), '0);
      va = '0; vb = '0; ve = '0;
      va[15:0] = 16'h8000; vb[15:0] = 16'h0001; ve[15:0] = 16'h8000;
      run_op("vsub sat", VOP_VSUB, 1'b1, va, vb, ve, 16'h0001);
      run_op("vand", VOP_VAND, 1'b0, fill(16'hF0F0), fill(16'h3C3C), fill(16'h3030), '0);
      run_op("vmul neg", VOP_VMUL, 1'b0, fill(16'hFFFD), fill(16'h0004), fill(16'hFFF4), '0);
      run_op("vmul wrap", VOP_VMUL, 1'b0, fill(16'h0100), fill(16'h0100), '0, '0);
      run_op("vmov", VOP_VMOV, 1'b0, fill(16'h1234), fill(16'hFFFF), fill(16'h1234), '0);
      run_op("accclr", VOP_ACCCLR, 1'b0, fill(16'h1111), fill(16'h2222), '0, '0);

      // Back-to-back VMAC chain
      @(negedge clk);
      in_valid = 1'b1; op = VOP_VMAC; sat = 1'b0; a = fill(16'h0002); b = fill(16'h0003);
      @(negedge clk);
      chk("mac in_ready", VW'(in_ready), VW'(1));
      @(negedge clk);
      chk("mac1 valid", VW'(out_valid), VW'(1));
      chk("mac1", result, fill(16'h0006));
      @(negedge clk);
      in_valid = 1'b0;
      chk("mac2", result, fill(16'h000C));
      @(negedge clk);
      chk("mac3", result, fill(16'h0012));
      chk("mac3 ovf", VW'(ovf_mask), '0);
      @(negedge clk);
      chk("mac drained", VW'(out_valid), VW'(0));

      va = '0;
      for (int i = 0; i < int'(LANES); i++) va[i*LANE_W +: LANE_W] = LANE_W'(i);
      ve = '0; ve[15:0] = 16'h0078;
      run_op("vdot", VOP_VDOT, 1'b0, va, fill(16'h0001), ve, '0);

      // Back-pressure: acc is 18 here
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; op = VOP_VMAC; a = fill(16'h0001); b = fill(16'h0001);
      @(negedge clk);
      chk("bp in_ready 1", VW'(in_ready), VW'(1));
      op = VOP_VADD;
      @(negedge clk);
      chk("bp valid", VW'(out_valid), VW'(1));
      chk("bp res0", result, fill(16'h0013));
      chk("bp in_ready drop", VW'(in_ready), VW'(0));
      op = VOP_VMAC;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp hold", result, fill(16'h0013));
         chk("bp stall ready", VW'(in_ready), VW'(0));
      end
      out_ready = 1'b1;
      #1;
      chk("bp release ready", VW'(in_ready), VW'(1));
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp res1", result, fill(16'h0002));
      @(negedge clk);
      chk("bp res2 valid", VW'(out_valid), VW'(1));
      chk("bp res2", result, fill(16'h0014));
      @(negedge clk);
      chk("bp drained", VW'(out_valid), VW'(0));

      // Reset mid-stream with acc nonzero
      @(negedge clk);
      in_valid = 1'b1; op = VOP_VMAC; a = fill(16'h0001); b = fill(16'h0001);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre-rst res", result, fill(16'h0015));
      rst_n = 1'b0;
      #1;
      chk("mid rst out_valid", VW'(out_valid), VW'(0));
      chk("mid rst result", result, '0);
      chk("mid rst zero", VW'(zero), VW'(1));
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post rst vmac", VOP_VMAC, 1'b0, fill(16'h0001), fill(16'h0001), fill(16'h0001), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
